inst_queue: RTL and testbench

Decoupling buffer between the instruction fetch stage and the decode stage. It accepts fetched (pc, inst) pairs over a valid/ready handshake and stores them in an in-order circular queue. Each entry is predecoded on enqueue into a predicted next PC and a taken flag, so decode and execute can detect mispredictions. The whole queue is discarded in one cycle on a jump or CSR/trap flush.

---
 rtl/inst_queue.sv | 110 +++++++++++
 tb/tb_inst_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// In-order fetch-to-decode instruction queue with enqueue-time branch/jal predecode.
// Single-cycle flush clears both pointers; entry contents are left as they are.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_pred_npc,
    output logic        out_pred_taken
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_inst  [DEPTH];
    logic [31:0]   r_npc   [DEPTH];
    logic          r_taken [DEPTH];

    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_deq;
    logic [4:0]    w_opcode;
    logic [31:0]   w_imm_b;
    logic [31:0]   w_imm_j;
    logic [31:0]   w_pred_npc;
    logic          w_pred_taken;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // in_ready is a pure function of the pointers, so out_ready never reaches it
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty & ~flush;

    assign w_enq = in_valid & ~w_full & ~flush;
    assign w_deq = out_valid & out_ready;

    assign w_opcode = in_inst[6:2];
    assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Static prediction: backward branches taken, forward not taken, jal always taken
    always_comb begin
        w_pred_npc   = in_pc + 32'd4;
        w_pred_taken = 1'b0;
        case (w_opcode)
            5'b11000: begin
                if (in_inst[31]) begin
                    w_pred_npc   = in_pc + w_imm_b;
                    w_pred_taken = 1'b1;
                end
            end
            5'b11011: begin
                w_pred_npc   = in_pc + w_imm_j;
                w_pred_taken = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_pc[gi]    <= '0;
                    r_inst[gi]  <= '0;
                    r_npc[gi]   <= '0;
                    r_taken[gi] <= 1'b0;
                end else if (w_enq && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_pc[gi]    <= in_pc;
                    r_inst[gi]  <= in_inst;
                    r_npc[gi]   <= w_pred_npc;
                    r_taken[gi] <= w_pred_taken;
                end
            end
        end
    endgenerate

    assign out_pc         = r_pc[r_rd_ptr[AW-1:0]];
    assign out_inst       = r_inst[r_rd_ptr[AW-1:0]];
    assign out_pred_npc   = r_npc[r_rd_ptr[AW-1:0]];
    assign out_pred_taken = r_taken[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: queue-based reference model checked every cycle,
// plus literal expectations taken from hand-decoded instructions.
module tb_inst_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_pred_npc;
    logic        out_pred_taken;

    int total = 0;
    int bad = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_npc(out_pred_npc), .out_pred_taken(out_pred_taken)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] npc;
        logic        tk;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Prediction from the instruction-set definition: offsets as signed integers
    function automatic ent_t predict(input logic [31:0] pc, input logic [31:0] inst);
        ent_t e;
        logic [12:0] b;
        logic [20:0] j;
        int off;
        b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        off = 4;
        e.tk = 1'b0;
        if (inst[6:2] == 5'b11000 && inst[31]) begin
            off = int'(b) - 8192;
            e.tk = 1'b1;
        end else if (inst[6:2] == 5'b11011) begin
            off = int'(j) - (inst[31] ? 2097152 : 0);
            e.tk = 1'b1;
        end
        e.pc = pc;
        e.inst = inst;
        e.npc = pc + 32'(off);
        return e;
    endfunction

    // Reference model: occupancy and order only
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit do_deq;
            bit do_enq;
            do_deq = (q.size() > 0) && out_ready;
            do_enq = in_valid && (q.size() < DEPTH);
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back(predict(in_pc, in_inst));
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_npc", out_pred_npc, 32'd0);
        end else begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
            chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0) && !flush});
            if (q.size() > 0 && !flush) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_inst", out_inst, q[0].inst);
                chk("out_pred_npc", out_pred_npc, q[0].npc);
                chk("out_pred_taken", {31'b0, out_pred_taken}, {31'b0, q[0].tk});
            end
        end
    end

    task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                         input logic [31:0] inst, input logic ordy);
        flush = fl;
        in_valid = iv;
        in_pc = pc;
        in_inst = inst;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        chk("lit_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("lit_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("lit_rst_inst", out_inst, 32'd0);
        chk("lit_rst_taken", {31'b0, out_pred_taken}, 32'd0);
        reset = 1'b0;
        tick();

        // Single nop: visible the cycle after the accepting edge
        drive(1'b0, 1'b1, 32'h8000_0000, NOP, 1'b0);
        tick();
        idle();
        #1;
        chk("lit_nop_valid", {31'b0, out_valid}, 32'd1);
        chk("lit_nop_pc", out_pc, 32'h8000_0000);
        chk("lit_nop_npc", out_pred_npc, 32'h8000_0004);
        chk("lit_nop_taken", {31'b0, out_pred_taken}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        idle();

        // Fill to full, then a blocked enqueue alongside a dequeue
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b1, 32'h8000_0000 + 32'(4 * k), NOP, 1'b0);
            tick();
        end
        idle();
        #1;
        chk("lit_full_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0900, NOP, 1'b1);
        #1;
        chk("lit_full_ready_ordy", {31'b0, in_ready}, 32'd0);
        tick();
        idle();
        #1;
        chk("lit_ready_after_deq", {31'b0, in_ready}, 32'd1);
        for (int k = 1; k < DEPTH; k++) begin
            chk("lit_drain_pc", out_pc, 32'h8000_0000 + 32'(4 * k));
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick();
        end
        idle();
        #1;
        chk("lit_drained_valid", {31'b0, out_valid}, 32'd0);

        // Backward branch and jal predecode
        drive(1'b0, 1'b1, 32'h8000_0010, 32'hFE00_0EE3, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h8000_0020, 32'h0080_006F, 1'b0);
        tick();
        idle();
        #1;
        chk("lit_beq_npc", out_pred_npc, 32'h8000_000C);
        chk("lit_beq_taken", {31'b0, out_pred_taken}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        idle();
        #1;
        chk("lit_jal_npc", out_pred_npc, 32'h8000_0028);
        chk("lit_jal_taken", {31'b0, out_pred_taken}, 32'd1);
        drive(1'b0, 1'b1, 32'h8000_0040, 32'h0000_0463, 1'b1);
        tick();
        idle();
        #1;
        chk("lit_fwd_beq_npc", out_pred_npc, 32'h8000_0044);
        chk("lit_fwd_beq_taken", {31'b0, out_pred_taken}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Flush with 3 entries and a simultaneous handshake on both sides
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h8000_0100 + 32'(4 * k), NOP, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1, 32'h8000_0200, NOP, 1'b1);
        #1;
        chk("lit_flush_valid", {31'b0, out_valid}, 32'd0);
        tick();
        idle();
        #1;
        chk("lit_postflush_valid", {31'b0, out_valid}, 32'd0);
        chk("lit_postflush_ready", {31'b0, in_ready}, 32'd1);
        drive(1'b0, 1'b1, 32'h8000_1000, NOP, 1'b0);
        tick();
        idle();
        #1;
        chk("lit_after_flush_pc", out_pc, 32'h8000_1000);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();

        // Two in flight, then 10 cycles of simultaneous enqueue/dequeue across the wrap
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 32'h8000_2000 + 32'(4 * k), NOP, 1'b0);
            tick();
        end
        for (int k = 2; k < 12; k++) begin
            drive(1'b0, 1'b1, 32'h8000_2000 + 32'(4 * k), NOP, 1'b1);
            tick();
        end
        idle();
        #1;
        chk("lit_stream_head", out_pc, 32'h8000_2028);
        chk("lit_stream_count", 32'(q.size()), 32'd2);

        // Fill, then an asynchronous reset between edges
        drive(1'b0, 1'b1, 32'h8000_3000, NOP, 1'b0);
        tick();
        drive(1'b0, 1'b1, 32'h8000_3004, NOP, 1'b0);
        tick();
        idle();
        #1;
        chk("lit_prerst_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("lit_async_valid", {31'b0, out_valid}, 32'd0);
        chk("lit_async_ready", {31'b0, in_ready}, 32'd1);
        #1 reset = 1'b0;
        tick();
        drive(1'b0, 1'b1, 32'h8000_4000, 32'h0100_006F, 1'b0);
        tick();
        idle();
        #1;
        chk("lit_postrst_pc", out_pc, 32'h8000_4000);
        chk("lit_postrst_npc", out_pred_npc, 32'h8000_4010);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
